// File: rtl/lz77_win_match.sv
// LZ77 token engine: history window with parallel compare, emits literal/match tokens for a
// scanline read from the filter FIFO, with output backpressure.
module lz77_win_match #(
    parameter int DATA_WD   = 8,
    parameter int WIN_DEPTH = 32,
    parameter int DST_WD    = 6,
    parameter int LEN_MIN   = 3,
    parameter int LEN_MAX   = 258,
    parameter int LEN_WD    = 9,
    parameter int SIZE_WD   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [SIZE_WD-1:0] cfg_len_i,
    input  logic               cfg_mode_i,
    input  logic               cfg_clr_i,
    output logic               done_o,
    output logic               fifo_rd_val_o,
    input  logic [DATA_WD-1:0] fifo_rd_dat_i,
    output logic               val_o,
    input  logic               rdy_i,
    output logic               flg_lit_o,
    output logic [DATA_WD-1:0] dat_lit_o,
    output logic [LEN_WD-1:0]  dat_len_o,
    output logic [DST_WD-1:0]  dat_dst_o,
    output logic               flg_lst_o
);
    localparam int BUF_N  = LEN_MIN - 1;
    localparam int CNT_WD = $clog2(LEN_MIN + 1);
    localparam int QD     = 2 ** CNT_WD;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_LITQ, S_FLUSH, S_DONE} state_t;

    // Valid/ready: a token transfers on a cycle where val_o & rdy_i; while val_o & ~rdy_i the
    // token fields hold and no FIFO reads are issued.

    state_t                            state_q, state_d;
    logic                              mode_q, mode_d;
    logic [SIZE_WD-1:0]                rd_rem_q, rd_rem_d, pr_rem_q, pr_rem_d;
    logic                              arr_q, arr_d;
    logic                              hold_vld_q, hold_vld_d;
    logic [DATA_WD-1:0]                hold_q, hold_d;
    logic [WIN_DEPTH-1:0][DATA_WD-1:0] win_q, win_d;
    logic [WIN_DEPTH-1:0]              wv_q, wv_d, cm_q, cm_d, cm_n, eq, nm;
    logic [LEN_WD-1:0]                 len_q, len_d, len_n, t_len;
    logic [DATA_WD-1:0]                buf_q [BUF_N];
    logic [DATA_WD-1:0]                buf_d [BUF_N];
    logic [DATA_WD-1:0]                buf_n [BUF_N];
    logic [DATA_WD-1:0]                lq_q [QD];
    logic [DATA_WD-1:0]                lq_d [QD];
    logic [DATA_WD-1:0]                lits [QD];
    logic [CNT_WD-1:0]                 lq_cnt_q, lq_cnt_d, n_lit, q_n;
    logic                              lq_lst_q, lq_lst_d;
    logic                              val_q, val_d, lit_q, lit_d, lst_q, lst_d, done_q, done_d;
    logic [DATA_WD-1:0]                dlit_q, dlit_d;
    logic [LEN_WD-1:0]                 dlen_q, dlen_d;
    logic [DST_WD-1:0]                 ddst_q, ddst_d, t_dst;
    logic                              t_match, out_free, rd_en, cur_vld, proc, last;
    logic [DATA_WD-1:0]                cur_byte;

    function automatic logic [DST_WD-1:0] near_dst(input logic [WIN_DEPTH-1:0] m);
        near_dst = '0;
        for (int k = WIN_DEPTH - 1; k >= 0; k--) begin
            if (m[k]) near_dst = DST_WD'(k + 1);
        end
    endfunction

    assign out_free      = !val_q || rdy_i;
    assign rd_en         = (state_q == S_READ) && (rd_rem_q != '0) && !hold_vld_q && out_free;
    assign cur_vld       = hold_vld_q || arr_q;
    assign cur_byte      = hold_vld_q ? hold_q : fifo_rd_dat_i;
    assign proc          = cur_vld && out_free && (state_q == S_READ);
    assign last          = (pr_rem_q == SIZE_WD'(1));
    assign fifo_rd_val_o = rd_en;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rd_rem_d   = rd_rem_q;
        pr_rem_d   = pr_rem_q;
        arr_d      = rd_en;
        hold_vld_d = cur_vld && !proc;
        hold_d     = hold_q;
        win_d      = win_q;
        wv_d       = wv_q;
        cm_d       = cm_q;
        len_d      = len_q;
        buf_d      = buf_q;
        lq_d       = lq_q;
        lq_cnt_d   = lq_cnt_q;
        lq_lst_d   = lq_lst_q;
        val_d      = val_q && !rdy_i;
        lit_d      = lit_q;
        dlit_d     = dlit_q;
        dlen_d     = dlen_q;
        ddst_d     = ddst_q;
        lst_d      = lst_q;
        done_d     = 1'b0;
        cm_n       = cm_q;
        len_n      = len_q;
        buf_n      = buf_q;
        lits       = '{default: '0};
        n_lit      = '0;
        q_n        = '0;
        t_match    = 1'b0;
        t_len      = '0;
        t_dst      = '0;
        for (int k = 0; k < WIN_DEPTH; k++) eq[k] = wv_q[k] && (win_q[k] == cur_byte);
        nm = cm_q & eq;

        if (arr_q && !hold_vld_q) hold_d = fifo_rd_dat_i;
        if (rd_en) rd_rem_d = rd_rem_q - SIZE_WD'(1);

        if (proc) begin
            win_d    = {win_q[WIN_DEPTH-2:0], cur_byte};
            wv_d     = {wv_q[WIN_DEPTH-2:0], 1'b1};
            pr_rem_d = pr_rem_q - SIZE_WD'(1);
            if (!mode_q) begin
                lits[0] = cur_byte;
                n_lit   = CNT_WD'(1);
            end else begin
                if (len_q != '0 && nm != '0) begin
                    len_n = len_q + LEN_WD'(1);
                    cm_n  = nm;
                    for (int i = 0; i < BUF_N; i++) if (i == int'(len_q)) buf_n[i] = cur_byte;
                    if (len_n == LEN_WD'(LEN_MAX)) begin
                        t_match = 1'b1;
                        t_len   = len_n;
                        t_dst   = near_dst(nm);
                        len_n   = '0;
                        cm_n    = '0;
                    end
                end else begin
                    if (len_q != '0) begin
                        if (int'(len_q) >= LEN_MIN) begin
                            t_match = 1'b1;
                            t_len   = len_q;
                            t_dst   = near_dst(cm_q);
                        end else begin
                            for (int i = 0; i < BUF_N; i++) begin
                                if (i < int'(len_q)) begin
                                    lits[n_lit] = buf_q[i];
                                    n_lit       = n_lit + CNT_WD'(1);
                                end
                            end
                        end
                    end
                    // The breaking byte starts over against the same pre-shift window.
                    if (eq != '0) begin
                        len_n    = LEN_WD'(1);
                        cm_n     = eq;
                        buf_n[0] = cur_byte;
                    end else begin
                        len_n       = '0;
                        cm_n        = '0;
                        lits[n_lit] = cur_byte;
                        n_lit       = n_lit + CNT_WD'(1);
                    end
                end
                if (last && len_n != '0) begin
                    if (int'(len_n) >= LEN_MIN) begin
                        t_match = 1'b1;
                        t_len   = len_n;
                        t_dst   = near_dst(cm_n);
                    end else begin
                        for (int i = 0; i < BUF_N; i++) begin
                            if (i < int'(len_n)) begin
                                lits[n_lit] = buf_n[i];
                                n_lit       = n_lit + CNT_WD'(1);
                            end
                        end
                    end
                    len_n = '0;
                    cm_n  = '0;
                end
            end
            len_d = len_n;
            cm_d  = cm_n;
            buf_d = buf_n;
            if (t_match || n_lit != '0) begin
                val_d = 1'b1;
                if (t_match) begin
                    lit_d  = 1'b0;
                    dlit_d = '0;
                    dlen_d = t_len;
                    ddst_d = t_dst;
                    q_n    = n_lit;
                    lq_d   = lits;
                end else begin
                    lit_d  = 1'b1;
                    dlit_d = lits[0];
                    dlen_d = '0;
                    ddst_d = '0;
                    q_n    = n_lit - CNT_WD'(1);
                    for (int j = 0; j < QD - 1; j++) lq_d[j] = lits[j+1];
                    lq_d[QD-1] = '0;
                end
                lq_cnt_d = q_n;
                lq_lst_d = last;
                lst_d    = last && (q_n == '0);
            end
            if (q_n != '0)  state_d = S_LITQ;
            else if (last)  state_d = S_FLUSH;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_READ;
                    rd_rem_d = cfg_len_i;
                    pr_rem_d = cfg_len_i;
                    mode_d   = cfg_mode_i;
                    len_d    = '0;
                    cm_d     = '0;
                    if (cfg_clr_i) wv_d = '0;
                end
            end
            S_LITQ: begin
                if (out_free) begin
                    val_d  = 1'b1;
                    lit_d  = 1'b1;
                    dlit_d = lq_q[0];
                    dlen_d = '0;
                    ddst_d = '0;
                    for (int j = 0; j < QD - 1; j++) lq_d[j] = lq_q[j+1];
                    lq_d[QD-1] = '0;
                    lq_cnt_d   = lq_cnt_q - CNT_WD'(1);
                    lst_d      = (lq_cnt_q == CNT_WD'(1)) && lq_lst_q;
                    if (lq_cnt_q == CNT_WD'(1)) state_d = (pr_rem_q == '0) ? S_FLUSH : S_READ;
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            rd_rem_q   <= '0;
            pr_rem_q   <= '0;
            arr_q      <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
            win_q      <= '0;
            wv_q       <= '0;
            cm_q       <= '0;
            len_q      <= '0;
            buf_q      <= '{default: '0};
            lq_q       <= '{default: '0};
            lq_cnt_q   <= '0;
            lq_lst_q   <= 1'b0;
            val_q      <= 1'b0;
            lit_q      <= 1'b0;
            dlit_q     <= '0;
            dlen_q     <= '0;
            ddst_q     <= '0;
            lst_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            rd_rem_q   <= rd_rem_d;
            pr_rem_q   <= pr_rem_d;
            arr_q      <= arr_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
            win_q      <= win_d;
            wv_q       <= wv_d;
            cm_q       <= cm_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
            lq_q       <= lq_d;
            lq_cnt_q   <= lq_cnt_d;
            lq_lst_q   <= lq_lst_d;
            val_q      <= val_d;
            lit_q      <= lit_d;
            dlit_q     <= dlit_d;
            dlen_q     <= dlen_d;
            ddst_q     <= ddst_d;
            lst_q      <= lst_d;
            done_q     <= done_d;
        end
    end

    assign val_o     = val_q;
    assign flg_lit_o = lit_q;
    assign dat_lit_o = dlit_q;
    assign dat_len_o = dlen_q;
    assign dat_dst_o = ddst_q;
    assign flg_lst_o = lst_q;
    assign done_o    = done_q;

endmodule
